cpu_ctrl: RTL and testbench

//  Instruction sequencer for the tinycpu datapath. Fetches opcodes from memory at rP, decodes them,
//  and drives write enables for rA/rB/rM, rP_inc/rP_load, the memory request handshake and the
//  ALU/data-source selects. Sits between the memory port and the CPU register block.

---
 rtl/cpu_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the tinycpu datapath: fetch/decode/execute FSM that drives
// register write strobes, PC control, the memory handshake and ALU/data-source selects.
module cpu_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] rA_out,
    output logic [2:0] alu_op,
    output logic       reg_src_sel,
    output logic [1:0] st_src_sel,
    output logic       rA_we,
    output logic       rB_we,
    output logic       rM_we,
    output logic       rP_inc,
    output logic       rP_load,
    output logic       halted,
    output logic       fault,
    output logic [7:0] ir
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

    state_t     state;
    logic [7:0] tcnt;

    logic is_nop, is_halt, is_ld, is_st, is_li, is_jmp, is_jz, is_alu;
    logic reg_wr, alu_wr;
    logic wait_hit, timed_out;

    always_comb begin
        is_nop  = (ir == 8'h00);
        is_halt = (ir == 8'h01);
        is_ld   = ir inside {[8'h10:8'h12]};
        is_st   = ir inside {[8'h20:8'h22]};
        is_li   = ir inside {[8'h30:8'h32]};
        is_jmp  = (ir == 8'h40);
        is_jz   = (ir == 8'h41);
        is_alu  = ir inside {[8'h50:8'h57]};
    end

    assign alu_op     = ir[2:0];
    assign st_src_sel = ir[1:0];

    // Strobes are gated by rst so they fall the instant reset asserts, even mid-transfer.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_src_sel  = 1'b0;
        reg_wr       = 1'b0;
        alu_wr       = 1'b0;
        rP_inc       = 1'b0;
        rP_load      = 1'b0;
        if (rst) begin
            case (state)
                FETCH: begin
                    mem_req = run;
                    rP_inc  = run && mem_ack;
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = is_ld || is_st;
                    mem_we       = is_st;
                    if (mem_ack) begin
                        reg_wr = is_ld || is_li;
                        rP_inc = is_li;
                    end
                end
                EXEC: begin
                    if (is_jmp || (is_jz && rA_out == 8'h00)) begin
                        rP_load = 1'b1;
                    end else if (is_alu) begin
                        reg_src_sel = 1'b1;
                        alu_wr      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        rA_we = (reg_wr && ir[1:0] == 2'd0) || alu_wr;
        rB_we = reg_wr && ir[1:0] == 2'd1;
        rM_we = reg_wr && ir[1:0] == 2'd2;
    end

    // The limit is hit on the TIMEOUT-th unacknowledged cycle; an ack on that cycle wins.
    assign wait_hit  = mem_req && !mem_ack;
    assign timed_out = (TIMEOUT != 8'd0) && wait_hit && (tcnt == TIMEOUT - 8'd1);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            ir     <= 8'h00;
            halted <= 1'b0;
            fault  <= 1'b0;
            tcnt   <= 8'd0;
        end else begin
            case (state)
                FETCH, MEM: begin
                    if (timed_out) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        fault  <= 1'b1;
                        tcnt   <= 8'd0;
                    end else if (mem_req && mem_ack) begin
                        tcnt <= 8'd0;
                        if (state == FETCH) begin
                            ir    <= mem_rdata;
                            state <= DECODE;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (wait_hit) begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DECODE: begin
                    // NOP passes through EXEC so every instruction spans three cycles.
                    if (is_nop || is_jmp || is_jz || is_alu) begin
                        state <= EXEC;
                    end else if (is_ld || is_st || is_li) begin
                        state <= MEM;
                    end else begin
                        state  <= HALT;
                        halted <= 1'b1;
                        fault  <= !is_halt;
                    end
                end
                EXEC:    state <= FETCH;
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: scripted memory responses, a queue of expected
// per-cycle strobe vectors, and inline checks of sticky status and latched fields.
module tb_cpu_ctrl;

    localparam logic [8:0] REQ  = 9'h100;
    localparam logic [8:0] WE   = 9'h080;
    localparam logic [8:0] ASEL = 9'h040;
    localparam logic [8:0] SRC  = 9'h020;
    localparam logic [8:0] WA   = 9'h010;
    localparam logic [8:0] WB   = 9'h008;
    localparam logic [8:0] WM   = 9'h004;
    localparam logic [8:0] INC  = 9'h002;
    localparam logic [8:0] LOAD = 9'h001;

    typedef struct {
        logic [8:0] v;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] rA_out = 8'h00;

    logic       mem_req, mem_we, mem_addr_sel, reg_src_sel;
    logic       rA_we, rB_we, rM_we, rP_inc, rP_load, halted, fault;
    logic [2:0] alu_op;
    logic [1:0] st_src_sel;
    logic [7:0] ir;

    logic       nt_mem_req, nt_mem_we, nt_mem_addr_sel, nt_reg_src_sel;
    logic       nt_rA_we, nt_rB_we, nt_rM_we, nt_rP_inc, nt_rP_load, nt_halted, nt_fault;
    logic [2:0] nt_alu_op;
    logic [1:0] nt_st_src_sel;
    logic [7:0] nt_ir;

    logic [8:0] strobes;
    assign strobes = {mem_req, mem_we, mem_addr_sel, reg_src_sel,
                      rA_we, rB_we, rM_we, rP_inc, rP_load};

    cpu_ctrl #(.TIMEOUT(8'd15)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rA_out(rA_out),
        .alu_op(alu_op), .reg_src_sel(reg_src_sel), .st_src_sel(st_src_sel),
        .rA_we(rA_we), .rB_we(rB_we), .rM_we(rM_we),
        .rP_inc(rP_inc), .rP_load(rP_load),
        .halted(halted), .fault(fault), .ir(ir)
    );

    cpu_ctrl #(.TIMEOUT(8'd0)) dut_nt (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(nt_mem_req), .mem_we(nt_mem_we), .mem_addr_sel(nt_mem_addr_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rA_out(rA_out),
        .alu_op(nt_alu_op), .reg_src_sel(nt_reg_src_sel), .st_src_sel(nt_st_src_sel),
        .rA_we(nt_rA_we), .rB_we(nt_rB_we), .rM_we(nt_rM_we),
        .rP_inc(nt_rP_inc), .rP_load(nt_rP_load),
        .halted(nt_halted), .fault(nt_fault), .ir(nt_ir)
    );

    always #5 clk = ~clk;

    // Scoreboard: one expected strobe vector per scripted cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (strobes !== e.v) begin
                errors++;
                $display("FAIL %s: strobes=%09b expected %09b", e.name, strobes, e.v);
            end
        end
    end

    task automatic cyc(input logic ack, input logic [7:0] rd, input logic [8:0] v,
                       input string name);
        exp_t e;
        mem_ack   = ack;
        mem_rdata = rd;
        e.v       = v;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; rA_out = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h55;
        @(posedge clk);
        #1;
        checks++;
        if (strobes !== 9'h000 || nt_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: strobes=%09b nt_req=%b expected 0", strobes, nt_mem_req);
        end
        checks++;
        if (halted !== 1'b0 || fault !== 1'b0 || ir !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: halted=%b fault=%b ir=%h expected 0 0 00", halted, fault, ir);
        end
        run = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_nop_stream();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h00, REQ | INC, "nop_fetch");
            cyc(1'b1, 8'h00, 9'h000,    "nop_decode");
            cyc(1'b1, 8'h00, 9'h000,    "nop_exec");
        end
        run = 1'b0;
        cyc(1'b1, 8'h00, 9'h000, "nop_run_low");
    endtask

    task automatic test_li_ld();
        do_reset();
        run = 1'b1;
        cyc(1'b0, 8'h00, REQ,            "li_fetch_wait0");
        cyc(1'b0, 8'h00, REQ,            "li_fetch_wait1");
        cyc(1'b1, 8'h30, REQ | INC,      "li_fetch_ack");
        cyc(1'b0, 8'h00, 9'h000,         "li_decode");
        cyc(1'b0, 8'h00, REQ,            "li_mem_wait0");
        cyc(1'b0, 8'h00, REQ,            "li_mem_wait1");
        cyc(1'b1, 8'hAB, REQ | WA | INC, "li_mem_ack");
        cyc(1'b0, 8'h00, REQ,            "ld_fetch_wait0");
        cyc(1'b0, 8'h00, REQ,            "ld_fetch_wait1");
        cyc(1'b1, 8'h10, REQ | INC,      "ld_fetch_ack");
        cyc(1'b0, 8'h00, 9'h000,         "ld_decode");
        cyc(1'b0, 8'h00, REQ | ASEL,     "ld_mem_wait0");
        cyc(1'b0, 8'h00, REQ | ASEL,     "ld_mem_wait1");
        run = 1'b0;
        cyc(1'b1, 8'h77, REQ | ASEL | WA, "ld_mem_ack_run_low");
        cyc(1'b1, 8'h00, 9'h000,          "fetch_held");
        checks++;
        if (ir !== 8'h10) begin
            errors++;
            $display("FAIL ld_ir: ir=%h expected 10", ir);
        end
    endtask

    task automatic test_ops();
        do_reset();
        run = 1'b1;
        rA_out = 8'h00;
        cyc(1'b1, 8'h41, REQ | INC, "jz0_fetch");
        cyc(1'b1, 8'h00, 9'h000,    "jz0_decode");
        cyc(1'b1, 8'h00, LOAD,      "jz0_exec");
        rA_out = 8'h05;
        cyc(1'b1, 8'h41, REQ | INC, "jz5_fetch");
        cyc(1'b1, 8'h00, 9'h000,    "jz5_decode");
        cyc(1'b1, 8'h00, 9'h000,    "jz5_exec");
        cyc(1'b1, 8'h40, REQ | INC, "jmp_fetch");
        cyc(1'b1, 8'h00, 9'h000,    "jmp_decode");
        cyc(1'b1, 8'h00, LOAD,      "jmp_exec");
        cyc(1'b1, 8'h21, REQ | INC, "st_fetch");
        cyc(1'b1, 8'h00, 9'h000,    "st_decode");
        cyc(1'b1, 8'h00, REQ | WE | ASEL, "st_mem");
        checks++;
        if (st_src_sel !== 2'd1) begin
            errors++;
            $display("FAIL st_src_sel: got %0d expected 1", st_src_sel);
        end
        cyc(1'b1, 8'h11, REQ | INC,        "ldb_fetch");
        cyc(1'b1, 8'h00, 9'h000,           "ldb_decode");
        cyc(1'b1, 8'h99, REQ | ASEL | WB,  "ldb_mem");
        cyc(1'b1, 8'h32, REQ | INC,        "lim_fetch");
        cyc(1'b1, 8'h00, 9'h000,           "lim_decode");
        cyc(1'b1, 8'h01, REQ | WM | INC,   "lim_mem");
        cyc(1'b1, 8'h53, REQ | INC,        "alu_fetch");
        cyc(1'b1, 8'h00, 9'h000,           "alu_decode");
        run = 1'b0;
        cyc(1'b1, 8'h00, SRC | WA,         "alu_exec");
        checks++;
        if (alu_op !== 3'd3 || halted !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL alu_status: alu_op=%0d halted=%b fault=%b expected 3 0 0",
                     alu_op, halted, fault);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        run = 1'b1;
        cyc(1'b1, 8'hFF, REQ | INC, "ill_fetch");
        checks++;
        if (halted !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL ill_early: halted=%b fault=%b expected 0 0", halted, fault);
        end
        cyc(1'b1, 8'h00, 9'h000, "ill_decode");
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1) begin
            errors++;
            $display("FAIL ill_status: halted=%b fault=%b expected 1 1", halted, fault);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 9'h000, "ill_halted_idle");
        do_reset();
        run = 1'b1;
        cyc(1'b1, 8'h01, REQ | INC, "halt_fetch");
        cyc(1'b1, 8'h00, 9'h000,    "halt_decode");
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL halt_status: halted=%b fault=%b expected 1 0", halted, fault);
        end
        cyc(1'b1, 8'h00, 9'h000, "halt_idle");
        run = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, REQ, "to_wait");
        cyc(1'b0, 8'h00, 9'h000, "to_dropped");
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1) begin
            errors++;
            $display("FAIL to_status: halted=%b fault=%b expected 1 1", halted, fault);
        end
        for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 9'h000, "to_halted_idle");
        checks++;
        if (nt_mem_req !== 1'b1 || nt_fault !== 1'b0) begin
            errors++;
            $display("FAIL to_disabled: req=%b fault=%b expected 1 0", nt_mem_req, nt_fault);
        end
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00, REQ, "to_lim_wait");
        cyc(1'b1, 8'h00, REQ | INC, "to_ack_at_limit");
        cyc(1'b0, 8'h00, 9'h000,    "to_ack_decode");
        checks++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL to_ack_wins: halted=%b fault=%b expected 0 0", halted, fault);
        end
        run = 1'b0;
    endtask

    task automatic test_rst_mid_st();
        do_reset();
        run = 1'b1;
        cyc(1'b1, 8'h20, REQ | INC,       "rst_st_fetch");
        cyc(1'b0, 8'h00, 9'h000,          "rst_st_decode");
        cyc(1'b0, 8'h00, REQ | WE | ASEL, "rst_st_mem_wait");
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || ir !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: req=%b we=%b ir=%h expected 0 0 00", mem_req, mem_we, ir);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 8'h00, REQ | INC, "post_rst_fetch");
        checks++;
        if (ir !== 8'h00 || halted !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_ir: ir=%h halted=%b expected 00 0", ir, halted);
        end
        run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nop_stream();
        test_li_ld();
        test_ops();
        test_illegal();
        test_timeout();
        test_rst_mid_st();
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
